// File: rtl/stop_watch_lap.sv
// BCD minutes:seconds.tenths stopwatch with prescaled tick, preset load,
// saturating countdown with done pulse, wrap pulse and lap display freeze.
module stop_watch_lap #(
   parameter int TICK_DIV = 10_000_000,
   parameter int MIN_MAX  = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        go,
   input  logic        clr,
   input  logic        dir,
   input  logic        load,
   input  logic [15:0] preset,
   input  logic        lap,
   output logic [3:0]  d3,
   output logic [3:0]  d2,
   output logic [3:0]  d1,
   output logic [3:0]  d0,
   output logic        lap_active,
   output logic        done,
   output logic        wrap
);

   localparam int          PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
   localparam logic [3:0]  M_LIM    = 4'(MIN_MAX);
   localparam logic [15:0] CNT_MAX  = {M_LIM, 4'd5, 4'd9, 4'd9};

   logic [15:0]   cnt_q, cnt_d;
   logic [15:0]   hold_q, hold_d;
   logic [PW-1:0] p_q, p_d;
   logic          lap_q, lap_d;
   logic          done_q, done_d;
   logic          wrap_q, wrap_d;
   logic          tick;

   function automatic logic [15:0] bcd_inc(input logic [15:0] c);
      logic [3:0] m, s1, s0, t;
      {m, s1, s0, t} = c;
      if (t != 4'd9) t = t + 4'd1;
      else begin
         t = 4'd0;
         if (s0 != 4'd9) s0 = s0 + 4'd1;
         else begin
            s0 = 4'd0;
            if (s1 != 4'd5) s1 = s1 + 4'd1;
            else begin
               s1 = 4'd0;
               m  = (m >= M_LIM) ? 4'd0 : m + 4'd1;
            end
         end
      end
      return {m, s1, s0, t};
   endfunction

   // Caller guarantees c is nonzero, so the minutes borrow never underflows.
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] m, s1, s0, t;
      {m, s1, s0, t} = c;
      if (t != 4'd0) t = t - 4'd1;
      else begin
         t = 4'd9;
         if (s0 != 4'd0) s0 = s0 - 4'd1;
         else begin
            s0 = 4'd9;
            if (s1 != 4'd0) s1 = s1 - 4'd1;
            else begin
               s1 = 4'd5;
               m  = m - 4'd1;
            end
         end
      end
      return {m, s1, s0, t};
   endfunction

   function automatic logic [15:0] clamp_preset(input logic [15:0] c);
      logic [3:0] m, s1, s0, t;
      m  = (c[15:12] > M_LIM) ? M_LIM : c[15:12];
      s1 = (c[11:8]  > 4'd5)  ? 4'd5  : c[11:8];
      s0 = (c[7:4]   > 4'd9)  ? 4'd9  : c[7:4];
      t  = (c[3:0]   > 4'd9)  ? 4'd9  : c[3:0];
      return {m, s1, s0, t};
   endfunction

   assign tick = go && (p_q == P_LAST);

   always_comb begin
      cnt_d  = cnt_q;
      hold_d = hold_q;
      p_d    = p_q;
      lap_d  = lap_q;
      done_d = 1'b0;
      wrap_d = 1'b0;
      if (clr) begin
         cnt_d = '0;
         p_d   = '0;
         lap_d = 1'b0;
      end else begin
         if (lap) begin
            if (!lap_q) begin
               hold_d = cnt_q;
               lap_d  = 1'b1;
            end else begin
               lap_d  = 1'b0;
            end
         end
         // A load swallows any tick landing on the same edge.
         if (load) begin
            cnt_d = clamp_preset(preset);
            p_d   = '0;
         end else begin
            if (go) p_d = tick ? '0 : p_q + PW'(1);
            if (tick) begin
               if (dir) begin
                  cnt_d  = bcd_inc(cnt_q);
                  wrap_d = (cnt_q == CNT_MAX);
               end else if (cnt_q != 16'h0000) begin
                  cnt_d  = bcd_dec(cnt_q);
                  done_d = (cnt_q == 16'h0001);
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         hold_q <= '0;
         p_q    <= '0;
         lap_q  <= 1'b0;
         done_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
         p_q    <= p_d;
         lap_q  <= lap_d;
         done_q <= done_d;
         wrap_q <= wrap_d;
      end
   end

   assign {d3, d2, d1, d0} = lap_q ? hold_q : cnt_q;
   assign lap_active       = lap_q;
   assign done             = done_q;
   assign wrap             = wrap_q;

endmodule

// File: tb/tb_stop_watch_lap.sv
// Randomised and directed bench for stop_watch_lap against a tenths-count model.
module tb_stop_watch_lap;

   localparam int TD   = 4;
   localparam int MM   = 9;
   localparam int NMAX = (MM + 1) * 600 - 1;

   logic        clk = 1'b0;
   logic        reset, go, clr, dir, load, lap;
   logic [15:0] preset;
   logic [3:0]  d3, d2, d1, d0;
   logic        lap_active, done, wrap;

   int checks = 0;
   int errors = 0;

   // Reference model: live count and lap hold kept as plain tenths of a second.
   int m_n, m_p, m_hold;
   bit m_lap, m_done, m_wrap;

   stop_watch_lap #(.TICK_DIV(TD), .MIN_MAX(MM)) dut (
      .clk(clk), .reset(reset), .go(go), .clr(clr), .dir(dir), .load(load),
      .preset(preset), .lap(lap), .d3(d3), .d2(d2), .d1(d1), .d0(d0),
      .lap_active(lap_active), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 600), 4'((v % 600) / 100), 4'((v % 100) / 10), 4'(v % 10)};
   endfunction

   function automatic logic [15:0] exp_disp();
      return to_bcd(m_lap ? m_hold : m_n);
   endfunction

   task automatic model_update();
      bit tk;
      int pv;
      pv = preset;
      if (reset) begin
         m_n = 0; m_p = 0; m_hold = 0; m_lap = 0; m_done = 0; m_wrap = 0;
      end else if (clr) begin
         m_n = 0; m_p = 0; m_lap = 0; m_done = 0; m_wrap = 0;
      end else begin
         tk = go && (m_p == TD - 1);
         m_done = 0;
         m_wrap = 0;
         if (lap) begin
            if (!m_lap) begin m_hold = m_n; m_lap = 1; end
            else m_lap = 0;
         end
         if (load) begin
            m_n = imin((pv >> 12) & 15, MM) * 600 + imin((pv >> 8) & 15, 5) * 100
                + imin((pv >> 4) & 15, 9) * 10 + imin(pv & 15, 9);
            m_p = 0;
         end else begin
            if (go) m_p = tk ? 0 : m_p + 1;
            if (tk) begin
               if (dir) begin
                  m_wrap = (m_n == NMAX);
                  m_n = (m_n + 1) % (NMAX + 1);
               end else if (m_n > 0) begin
                  m_done = (m_n == 1);
                  m_n = m_n - 1;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic strobe_load(input logic [15:0] v);
      preset = v; load = 1'b1;
      cycle();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; go = 1'b1; lap = 1'b1; load = 1'b1; preset = 16'h1234;
      cycle(); cycle();
      reset = 1'b0; go = 1'b0; lap = 1'b0; load = 1'b0;
      checks++; if ({d3, d2, d1, d0} !== 16'h0000) begin errors++; $display("FAIL reset_disp got %h want 0000", {d3, d2, d1, d0}); end
      checks++; if (lap_active !== 1'b0) begin errors++; $display("FAIL reset_lap got %b want 0", lap_active); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
   endtask

   task automatic test_up_count();
      go = 1'b1; dir = 1'b1;
      for (int c = 1; c <= 42; c++) begin
         cycle();
         checks++;
         if ({d3, d2, d1, d0} !== exp_disp()) begin errors++; $display("FAIL up_model c=%0d got %h want %h", c, {d3, d2, d1, d0}, exp_disp()); end
         if (c == 4) begin
            checks++; if ({d3, d2, d1, d0} !== 16'h0001) begin errors++; $display("FAIL up_first got %h want 0001", {d3, d2, d1, d0}); end
         end
         if (c == 40) begin
            checks++; if ({d3, d2, d1, d0} !== 16'h0010) begin errors++; $display("FAIL up_40 got %h want 0010", {d3, d2, d1, d0}); end
         end
      end
      go = 1'b0;
      for (int c = 0; c < 6; c++) cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0010) begin errors++; $display("FAIL pause_hold got %h want 0010", {d3, d2, d1, d0}); end
      go = 1'b1;
      cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0010) begin errors++; $display("FAIL resume_1 got %h want 0010", {d3, d2, d1, d0}); end
      cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0011) begin errors++; $display("FAIL resume_2 got %h want 0011", {d3, d2, d1, d0}); end
   endtask

   task automatic test_rollover();
      go = 1'b1; dir = 1'b1;
      strobe_load(16'h9599);
      checks++; if ({d3, d2, d1, d0} !== 16'h9599) begin errors++; $display("FAIL roll_load got %h want 9599", {d3, d2, d1, d0}); end
      for (int c = 0; c < 3; c++) cycle();
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL roll_early_wrap got %b want 0", wrap); end
      cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0000) begin errors++; $display("FAIL roll_zero got %h want 0000", {d3, d2, d1, d0}); end
      checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL roll_wrap got %b want 1", wrap); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL roll_done got %b want 0", done); end
      cycle();
      checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL roll_wrap_len got %b want 0", wrap); end
   endtask

   task automatic test_countdown();
      int pulses;
      go = 1'b1; dir = 1'b0;
      strobe_load(16'h0010);
      pulses = 0;
      for (int k = 1; k <= 15; k++) begin
         for (int c = 0; c < TD; c++) begin
            cycle();
            if (done === 1'b1) pulses++;
         end
         checks++;
         if ({d3, d2, d1, d0} !== to_bcd((k < 10) ? 10 - k : 0)) begin errors++; $display("FAIL down_tick k=%0d got %h want %h", k, {d3, d2, d1, d0}, to_bcd((k < 10) ? 10 - k : 0)); end
         if (k == 10) begin
            checks++; if (done !== 1'b1) begin errors++; $display("FAIL down_done got %b want 1", done); end
         end
      end
      checks++; if (pulses != 1) begin errors++; $display("FAIL down_pulses got %0d want 1", pulses); end
   endtask

   task automatic test_borrow_dir();
      go = 1'b1; dir = 1'b0;
      strobe_load(16'h1000);
      for (int c = 0; c < TD; c++) cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0599) begin errors++; $display("FAIL borrow got %h want 0599", {d3, d2, d1, d0}); end
      cycle(); cycle();
      dir = 1'b1;
      cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h0599) begin errors++; $display("FAIL dir_mid got %h want 0599", {d3, d2, d1, d0}); end
      cycle();
      checks++; if ({d3, d2, d1, d0} !== 16'h1000) begin errors++; $display("FAIL dir_flip got %h want 1000", {d3, d2, d1, d0}); end
   endtask

   task automatic test_lap();
      int guard;
      clr = 1'b1; cycle(); clr = 1'b0;
      go = 1'b1; dir = 1'b1;
      guard = 0;
      while (m_n != 32 && guard < 500) begin cycle(); guard++; end
      checks++; if ({d3, d2, d1, d0} !== 16'h0032) begin errors++; $display("FAIL lap_pre got %h want 0032", {d3, d2, d1, d0}); end
      lap = 1'b1; cycle(); lap = 1'b0;
      guard = 0;
      while (m_n != 50 && guard < 500) begin
         checks++;
         if ({d3, d2, d1, d0} !== 16'h0032 || lap_active !== 1'b1) begin errors++; $display("FAIL lap_freeze got %h/%b want 0032/1", {d3, d2, d1, d0}, lap_active); end
         cycle(); guard++;
      end
      checks++; if (guard >= 500) begin errors++; $display("FAIL lap_timeout got %0d want <500", guard); end
      lap = 1'b1; cycle(); lap = 1'b0;
      checks++; if ({d3, d2, d1} !== 12'h005 || lap_active !== 1'b0) begin errors++; $display("FAIL lap_release got %h/%b want 005x/0", {d3, d2, d1, d0}, lap_active); end
   endtask

   task automatic test_priority();
      go = 1'b1; dir = 1'b1;
      strobe_load(16'h9599);
      for (int c = 0; c < TD - 1; c++) cycle();
      clr = 1'b1; load = 1'b1; preset = 16'h4321;
      cycle();
      clr = 1'b0; load = 1'b0;
      checks++; if ({d3, d2, d1, d0} !== 16'h0000 || done !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL prio_clr got %h d%b w%b want 0000 d0 w0", {d3, d2, d1, d0}, done, wrap); end
      strobe_load(16'hC7AB);
      checks++; if ({d3, d2, d1, d0} !== 16'h9599) begin errors++; $display("FAIL clamp got %h want 9599", {d3, d2, d1, d0}); end
      dir = 1'b0;
      strobe_load(16'h0001);
      for (int c = 0; c < TD - 1; c++) cycle();
      strobe_load(16'h0003);
      checks++; if ({d3, d2, d1, d0} !== 16'h0003 || done !== 1'b0) begin errors++; $display("FAIL load_tick got %h d%b want 0003 d0", {d3, d2, d1, d0}, done); end
      lap = 1'b1; cycle(); lap = 1'b0;
      checks++; if (lap_active !== 1'b1) begin errors++; $display("FAIL prio_lap_on got %b want 1", lap_active); end
      reset = 1'b1; lap = 1'b1; load = 1'b1; preset = 16'h1111;
      cycle();
      reset = 1'b0; lap = 1'b0; load = 1'b0;
      checks++; if (lap_active !== 1'b0 || {d3, d2, d1, d0} !== 16'h0000) begin errors++; $display("FAIL reset_lap got %b/%h want 0/0000", lap_active, {d3, d2, d1, d0}); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         reset  = ($urandom_range(0, 499) == 0);
         clr    = ($urandom_range(0, 79) == 0);
         load   = ($urandom_range(0, 39) == 0);
         lap    = ($urandom_range(0, 29) == 0);
         go     = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 59) == 0) dir = ~dir;
         preset = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'h9598 + 16'($urandom_range(0, 1));
         cycle();
         checks++;
         if ({d3, d2, d1, d0} !== exp_disp() || lap_active !== m_lap || done !== m_done || wrap !== m_wrap)
         begin
            errors++;
            $display("FAIL rand i=%0d got %h l%b d%b w%b want %h l%b d%b w%b", i, {d3, d2, d1, d0},
                     lap_active, done, wrap, exp_disp(), m_lap, m_done, m_wrap);
         end
      end
      reset = 1'b0; clr = 1'b0; load = 1'b0; lap = 1'b0;
   endtask

   initial begin
      reset = 1'b1; go = 1'b0; clr = 1'b0; dir = 1'b1; load = 1'b0; lap = 1'b0; preset = '0;
      m_n = 0; m_p = 0; m_hold = 0; m_lap = 0; m_done = 0; m_wrap = 0;
      test_reset();
      test_up_count();
      test_rollover();
      test_countdown();
      test_borrow_dir();
      test_lap();
      test_priority();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
